// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for OPB software registers.
//   - word offsets inside the 16-byte register window
//   - bit positions of the flags in the STATUS word
//   - state encoding of the IDLE/ACK/RECOVER transfer sequencer
package opb_sw_reg_pkg;

    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CONTROL = 2'd2;

    localparam int STAT_NEW_DATA = 31;
    localparam int STAT_OVERRUN  = 30;
    localparam int STAT_ARMED    = 29;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RECOVER = 2'd2
    } ack_state_t;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and transfer sequencer for a small OPB slave.
// A selected access inside [BASEADDR, HIGHADDR] moves IDLE -> ACK; the ACK
// state acknowledges for exactly one cycle, then RECOVER swallows the cycle
// in which the master still holds select, and the sequencer returns to IDLE.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   abus         OPB address (big-endian bit numbering)
//   select, rnw  OPB transfer select and read/not-write
//   ack          one-cycle transfer acknowledge
//   rd_strobe    ack of a read transfer
//   wr_strobe    ack of a write transfer
//   offset       word offset of the acknowledged access
//   state        current sequencer state (observation only)
//
// Handshake: select is held by the master until it sees ack; ack is high for
// one cycle, one cycle after select rises, and an access is accepted only
// from IDLE, so transfers are acknowledged at most once every 3 cycles.
module opb_slave_ack_fsm
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] BASEADDR = 32'h0100_0900,
    parameter logic [31:0] HIGHADDR = 32'h0100_09FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] abus,
    input  logic        select,
    input  logic        rnw,
    output logic        ack,
    output logic        rd_strobe,
    output logic        wr_strobe,
    output logic [1:0]  offset,
    output ack_state_t  state
);

    logic hit;
    logic rnw_q;

    assign hit = select && (abus >= BASEADDR) && (abus <= HIGHADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            offset <= 2'd0;
            rnw_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state  <= ACK;
                        offset <= abus[28:29];
                        rnw_q  <= rnw;
                    end
                end
                ACK:     state <= RECOVER;
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ack       = (state == ACK);
    assign rd_strobe = ack & rnw_q;
    assign wr_strobe = ack & ~rnw_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB software register carrying a 32-bit snapshot from user logic to the PPC.
// User logic strobes user_valid to capture user_data_in; software polls STATUS
// for new_data / overrun / armed / capture count and reads DATA, which clears
// new_data. In one-shot mode a capture happens only while armed, and each
// capture disarms.
//
// Ports:
//   OPB_Clk, OPB_Rst_n        clock, synchronous active-low reset
//   OPB_ABus/BE/DBus/RNW/select/seqAddr   OPB master side (BE, seqAddr unused)
//   Sl_DBus, Sl_xferAck       read data (zero outside ack) and acknowledge
//   Sl_errAck/retry/toutSup   tied low
//   user_data_in, user_valid  value to snapshot and its capture strobe
//   user_ready                high while no unread snapshot is pending
//   user_armed                current arm state
//
// Register map (word offsets): 0x0 DATA, 0x4 STATUS, 0x8 CONTROL, 0xC zero.
module opb_register_simulink2ppc_snap
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0900,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_09FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          C_ONESHOT    = 0
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid,
    output logic        user_ready,
    output logic        user_armed
);

    logic        ack;
    logic        rd_strobe;
    logic        wr_strobe;
    logic [1:0]  offset;
    ack_state_t  fsm_state;

    logic [31:0] snap;
    logic        new_data;
    logic        overrun;
    logic [15:0] count;
    logic        armed;

    logic [31:0] wdata;
    logic [31:0] status_word;
    logic [31:0] rdata;
    logic        cap;
    logic        data_rd;
    logic        ctrl_wr;
    logic        ctrl_clr;
    logic        ctrl_arm;
    logic        unused_ok;

    opb_slave_ack_fsm #(
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk       (OPB_Clk),
        .rst_n     (OPB_Rst_n),
        .abus      (OPB_ABus),
        .select    (OPB_select),
        .rnw       (OPB_RNW),
        .ack       (ack),
        .rd_strobe (rd_strobe),
        .wr_strobe (wr_strobe),
        .offset    (offset),
        .state     (fsm_state)
    );

    // Re-number the bus so wdata[0] is the least significant bit.
    assign wdata    = OPB_DBus;

    assign cap      = user_valid & ((C_ONESHOT == 0) | armed);
    assign data_rd  = rd_strobe & (offset == OFF_DATA);
    assign ctrl_wr  = wr_strobe & (offset == OFF_CONTROL);
    assign ctrl_clr = ctrl_wr & wdata[1];
    assign ctrl_arm = ctrl_wr & wdata[0];

    always_comb begin
        status_word                = '0;
        status_word[STAT_NEW_DATA] = new_data;
        status_word[STAT_OVERRUN]  = overrun;
        status_word[STAT_ARMED]    = armed;
        status_word[15:0]          = count;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_DATA:   rdata = snap;
            OFF_STATUS: rdata = status_word;
            default:    rdata = '0;
        endcase
    end

    // Read data is driven only while a read is being acknowledged, so the
    // bus sees the pre-capture snap when a capture lands in the ack cycle.
    assign Sl_DBus    = rd_strobe ? rdata : '0;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            snap     <= '0;
            new_data <= 1'b0;
            overrun  <= 1'b0;
            count    <= '0;
            armed    <= 1'b0;
        end else begin
            if (cap) begin
                snap <= user_data_in;
            end

            // Set beats the read-clear so a capture in the read's ack cycle
            // is still flagged as unread.
            if (cap) begin
                new_data <= 1'b1;
            end else if (data_rd) begin
                new_data <= 1'b0;
            end

            // Overrun only when an unread snapshot is overwritten; a
            // concurrent DATA read means the old value was consumed.
            if (ctrl_clr) begin
                overrun <= 1'b0;
            end else if (cap && new_data && !data_rd) begin
                overrun <= 1'b1;
            end

            if (ctrl_clr) begin
                count <= cap ? 16'd1 : 16'd0;
            end else if (cap) begin
                count <= count + 16'd1;
            end

            // Arm is applied after the capture's disarm.
            if (ctrl_arm) begin
                armed <= 1'b1;
            end else if (cap && (C_ONESHOT != 0)) begin
                armed <= 1'b0;
            end
        end
    end

    assign user_ready = ~new_data;
    assign user_armed = armed;

    assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata[31:2], fsm_state,
                         C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench: instance 0 runs continuous capture, instance 1 one-shot.
// Both share address/data/strobe-data lines but have separate selects and
// user_valid strobes.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] A_DATA   = 32'h0100_0900;
    localparam logic [31:0] A_STATUS = 32'h0100_0904;
    localparam logic [31:0] A_CTRL   = 32'h0100_0908;
    localparam logic [31:0] A_RSVD   = 32'h0100_090C;

    logic        clk;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:31] dbus_w;
    logic        rnw;
    logic [31:0] udata;
    logic        sel0, sel1;
    logic        uvalid0, uvalid1;

    logic [0:31] sdbus0, sdbus1;
    logic        ack0, ack1;
    logic        err0, err1, retry0, retry1, tout0, tout1;
    logic        ready0, ready1, armed0, armed1;

    int checks;
    int failures;

    opb_register_simulink2ppc_snap #(.C_ONESHOT(0)) dut0 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(4'hF),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(1'b0),
        .Sl_DBus(sdbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(retry0),
        .Sl_toutSup(tout0), .user_data_in(udata), .user_valid(uvalid0),
        .user_ready(ready0), .user_armed(armed0)
    );

    opb_register_simulink2ppc_snap #(.C_ONESHOT(1)) dut1 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(4'hF),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(1'b0),
        .Sl_DBus(sdbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(retry1),
        .Sl_toutSup(tout1), .user_data_in(udata), .user_valid(uvalid1),
        .user_ready(ready1), .user_armed(armed1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic get_ack(input int inst);
        return (inst == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [31:0] get_dbus(input int inst);
        return (inst == 0) ? sdbus0 : sdbus1;
    endfunction

    task automatic set_sel(input int inst, input logic v);
        if (inst == 0) sel0 = v; else sel1 = v;
    endtask

    task automatic set_valid(input int inst, input logic v);
        if (inst == 0) uvalid0 = v; else uvalid1 = v;
    endtask

    // One OPB transfer; optionally strobes user_valid during the ack cycle.
    task automatic xfer(input int inst, input logic is_read, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic cap,
                        input logic [31:0] cap_data, output logic [31:0] rdata);
        @(negedge clk);
        abus   = addr;
        rnw    = is_read;
        dbus_w = wdata;
        set_sel(inst, 1'b1);
        #1;
        check_eq("dbus_before_ack", get_dbus(inst), 32'h0);
        check_eq("ack_early", {31'b0, get_ack(inst)}, 32'h0);
        @(posedge clk); #1;
        check_eq("ack_latency", {31'b0, get_ack(inst)}, 32'h1);
        rdata = get_dbus(inst);
        if (!is_read) check_eq("dbus_on_write", rdata, 32'h0);
        if (cap) begin
            udata = cap_data;
            set_valid(inst, 1'b1);
        end
        @(negedge clk);
        set_sel(inst, 1'b0);
        @(posedge clk); #1;
        set_valid(inst, 1'b0);
        check_eq("ack_width", {31'b0, get_ack(inst)}, 32'h0);
        check_eq("dbus_after_ack", get_dbus(inst), 32'h0);
        @(posedge clk);
    endtask

    task automatic rd(input int inst, input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        xfer(inst, 1'b1, addr, 32'h0, 1'b0, 32'h0, r);
        check_eq(tag, r, exp);
    endtask

    task automatic wr(input int inst, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        xfer(inst, 1'b0, addr, data, 1'b0, 32'h0, r);
    endtask

    task automatic pulse(input int inst, input logic [31:0] d);
        @(negedge clk);
        udata = d;
        set_valid(inst, 1'b1);
        @(negedge clk);
        set_valid(inst, 1'b0);
    endtask

    task automatic no_ack_at(input logic [31:0] addr, input string tag);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        abus = addr;
        rnw  = 1'b1;
        sel0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | ack0;
        end
        @(negedge clk);
        sel0 = 1'b0;
        check_eq(tag, {31'b0, seen}, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        abus     = '0;
        dbus_w   = '0;
        rnw      = 1'b1;
        udata    = '0;
        sel0     = 1'b0;
        sel1     = 1'b0;
        uvalid0  = 1'b0;
        uvalid1  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {31'b0, ack0}, 32'h0);
        check_eq("rst_dbus", sdbus0, 32'h0);
        check_eq("rst_ready", {31'b0, ready0}, 32'h1);
        check_eq("rst_armed", {31'b0, armed1}, 32'h0);
        check_eq("tied_low", {29'b0, err0 | err1, retry0 | retry1, tout0 | tout1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- continuous-capture instance ----
        rd(0, A_STATUS, 32'h0000_0000, "status_reset");
        pulse(0, 32'hDEAD_BEEF);
        check_eq("ready_after_cap", {31'b0, ready0}, 32'h0);
        rd(0, A_STATUS, 32'h8000_0001, "status_one_cap");
        rd(0, A_DATA,   32'hDEAD_BEEF, "data_one_cap");
        rd(0, A_STATUS, 32'h0000_0001, "status_after_read");
        check_eq("ready_after_read", {31'b0, ready0}, 32'h1);

        wr(0, A_CTRL, 32'h2);
        rd(0, A_STATUS, 32'h0000_0000, "status_cleared");
        pulse(0, 32'h11);
        pulse(0, 32'h22);
        rd(0, A_STATUS, 32'hC000_0002, "status_overrun");
        wr(0, A_CTRL, 32'h2);
        rd(0, A_STATUS, 32'h8000_0000, "status_clr_ovr");
        rd(0, A_DATA,   32'h22, "data_second");
        rd(0, A_STATUS, 32'h0000_0000, "status_consumed");

        // Capture in the ack cycle of a DATA read.
        xfer(0, 1'b1, A_DATA, 32'h0, 1'b1, 32'h33, r);
        check_eq("data_race_old", r, 32'h22);
        rd(0, A_STATUS, 32'h8000_0001, "status_race");
        rd(0, A_DATA,   32'h33, "data_race_new");

        // Capture in the ack cycle of a clearing CONTROL write.
        pulse(0, 32'h55);
        xfer(0, 1'b0, A_CTRL, 32'h2, 1'b1, 32'h66, r);
        rd(0, A_STATUS, 32'h8000_0001, "status_clr_race");
        rd(0, A_DATA,   32'h66, "data_clr_race");

        // Ignored writes and zero registers.
        wr(0, A_DATA, 32'hFFFF_FFFF);
        wr(0, A_STATUS, 32'hFFFF_FFFF);
        rd(0, A_DATA,   32'h66, "data_write_ignored");
        rd(0, A_CTRL,   32'h0, "ctrl_reads_zero");
        rd(0, A_RSVD,   32'h0, "rsvd_reads_zero");
        rd(0, A_STATUS, 32'h0000_0001, "status_write_ignored");

        // Arm is stored but does not gate capture here.
        wr(0, A_CTRL, 32'h1);
        check_eq("armed_cont", {31'b0, armed0}, 32'h1);
        rd(0, A_STATUS, 32'h2000_0001, "status_armed_cont");
        pulse(0, 32'h77);
        check_eq("armed_kept_cont", {31'b0, armed0}, 32'h1);
        rd(0, A_STATUS, 32'hA000_0002, "status_cap_armed");

        // ---- one-shot instance ----
        rd(1, A_STATUS, 32'h0000_0000, "os_status_reset");
        pulse(1, 32'hAA);
        rd(1, A_STATUS, 32'h0000_0000, "os_unarmed_ignored");
        wr(1, A_CTRL, 32'h1);
        check_eq("os_armed", {31'b0, armed1}, 32'h1);
        rd(1, A_STATUS, 32'h2000_0000, "os_status_armed");
        pulse(1, 32'h5A5A_5A5A);
        check_eq("os_disarmed", {31'b0, armed1}, 32'h0);
        rd(1, A_STATUS, 32'h8000_0001, "os_status_cap");
        pulse(1, 32'h99);
        rd(1, A_STATUS, 32'h8000_0001, "os_second_ignored");
        rd(1, A_DATA,   32'h5A5A_5A5A, "os_data");
        wr(1, A_CTRL, 32'h1);
        xfer(1, 1'b0, A_CTRL, 32'h1, 1'b1, 32'h77, r);
        check_eq("os_arm_race", {31'b0, armed1}, 32'h1);
        rd(1, A_STATUS, 32'hA000_0002, "os_status_arm_race");
        rd(1, A_DATA,   32'h77, "os_data_arm_race");

        // ---- count wrap on instance 0 ----
        wr(0, A_CTRL, 32'h2);
        rd(0, A_STATUS, 32'hA000_0000, "status_pre_wrap");
        @(negedge clk);
        udata   = 32'h1234_5678;
        uvalid0 = 1'b1;
        repeat (65535) @(negedge clk);
        uvalid0 = 1'b0;
        rd(0, A_STATUS, 32'hE000_FFFF, "count_ffff");
        pulse(0, 32'h9ABC_DEF0);
        rd(0, A_STATUS, 32'hE000_0000, "count_wrap");
        rd(0, A_DATA,   32'h9ABC_DEF0, "data_after_wrap");

        // ---- outside the window ----
        no_ack_at(32'h0100_0A00, "oor_above");
        no_ack_at(32'h0100_08FC, "oor_below");

        // ---- reset arriving with a transfer ----
        @(negedge clk);
        abus  = A_STATUS;
        rnw   = 1'b1;
        sel0  = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_ack", {31'b0, ack0}, 32'h0);
        @(negedge clk);
        sel0  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_armed", {31'b0, armed0}, 32'h0);
        check_eq("rst_mid_ready", {31'b0, ready0}, 32'h1);
        rd(0, A_STATUS, 32'h0000_0000, "status_after_rst");
        rd(0, A_DATA,   32'h0000_0000, "data_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
